audio_psg_sequencer: RTL and testbench

//  Per-sample scheduler for the 16-voice PSG. On each sample tick it sweeps the voice attribute RAM
//  (16 x 32-bit words, 1-cycle registered read) in voice order 0..15.
//  For each voice it advances a 17-bit phase accumulator held in internal registers by the voice

---
 rtl/audio_psg_sequencer_if.sv | 38 +++
 rtl/audio_psg_sequencer.sv | 153 +++++++++++++++
 tb/tb_audio_psg_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_psg_sequencer_if.sv
// Bus between the PSG sample scheduler and its neighbours: attribute RAM read
// port, decoded voice stream towards the waveform generator, and sweep status.
interface audio_psg_sequencer_if #(
    parameter int PHASE_W = 17
);
    logic               sample_tick_i;
    logic               overrun_clr_i;
    logic               attr_rd_en_o;
    logic [3:0]         attr_rd_addr_o;
    logic [31:0]        attr_rd_data_i;
    logic               voice_valid_o;
    logic [3:0]         voice_idx_o;
    logic [PHASE_W-1:0] voice_phase_o;
    logic [5:0]         voice_volume_o;
    logic               voice_left_o;
    logic               voice_right_o;
    logic [5:0]         voice_pw_o;
    logic [1:0]         voice_wave_o;
    logic               busy_o;
    logic               sweep_done_o;
    logic               overrun_o;

    modport master (
        input  sample_tick_i, overrun_clr_i, attr_rd_data_i,
        output attr_rd_en_o, attr_rd_addr_o,
        output voice_valid_o, voice_idx_o, voice_phase_o, voice_volume_o,
        output voice_left_o, voice_right_o, voice_pw_o, voice_wave_o,
        output busy_o, sweep_done_o, overrun_o
    );

    modport slave (
        output sample_tick_i, overrun_clr_i, attr_rd_data_i,
        input  attr_rd_en_o, attr_rd_addr_o,
        input  voice_valid_o, voice_idx_o, voice_phase_o, voice_volume_o,
        input  voice_left_o, voice_right_o, voice_pw_o, voice_wave_o,
        input  busy_o, sweep_done_o, overrun_o
    );
endinterface

// File: rtl/audio_psg_sequencer.sv
// Per-sample voice scheduler: on each tick, reads all 16 voice attribute words,
// advances each voice's phase accumulator and streams decoded voices, one per cycle.
module audio_psg_sequencer #(
    parameter int PHASE_W = 17
) (
    input logic                  clk,
    input logic                  rst,
    audio_psg_sequencer_if.master bus
);
    localparam int         NUM_VOICES = 16;
    localparam logic [3:0] LAST_VOICE = 4'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [3:0]         idx;
        logic [PHASE_W-1:0] phase;
        logic [5:0]         volume;
        logic               left;
        logic               right;
        logic [5:0]         pw;
        logic [1:0]         wave;
    } voice_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               tick_q;
    logic               busy;
    logic               start;
    logic               overrun_set;
    logic               overrun_q;

    logic               rd_vld_q;
    logic [3:0]         rd_idx_q;
    logic [PHASE_W-1:0] phase_q [NUM_VOICES];
    logic [PHASE_W-1:0] phase_sum;

    voice_t             voice_q;
    logic               voice_valid_q;
    logic               sweep_done_q;

    // The accepted tick spends one cycle in tick_q so address 0 lands one cycle after it.
    assign busy        = (state_q != IDLE);
    assign start       = bus.sample_tick_i && !busy && !tick_q;
    assign overrun_set = bus.sample_tick_i && (busy || tick_q);

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= start;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (tick_q) begin
                    state_d = ISSUE;
                    cnt_d   = '0;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_VOICE) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.attr_rd_en_o   = (state_q == ISSUE);
    assign bus.attr_rd_addr_o = (state_q == ISSUE) ? cnt_q : 4'd0;
    assign bus.busy_o         = busy;

    // Frequency is zero-extended; the carry out of the top bit is dropped.
    assign phase_sum = phase_q[rd_idx_q] + PHASE_W'(bus.attr_rd_data_i[15:0]);

    // NOTE: the phase accumulators are plain flops, so they are cleared with the rest of the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q      <= 1'b0;
            rd_idx_q      <= '0;
            voice_valid_q <= 1'b0;
            sweep_done_q  <= 1'b0;
            voice_q       <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_q[v] <= '0;
            end
        end else begin
            rd_vld_q      <= bus.attr_rd_en_o;
            rd_idx_q      <= bus.attr_rd_addr_o;
            voice_valid_q <= rd_vld_q;
            sweep_done_q  <= rd_vld_q && (rd_idx_q == LAST_VOICE);
            if (rd_vld_q) begin
                phase_q[rd_idx_q] <= phase_sum;
                voice_q.idx       <= rd_idx_q;
                voice_q.phase     <= phase_sum;
                voice_q.volume    <= bus.attr_rd_data_i[21:16];
                voice_q.left      <= bus.attr_rd_data_i[22];
                voice_q.right     <= bus.attr_rd_data_i[23];
                voice_q.pw        <= bus.attr_rd_data_i[29:24];
                voice_q.wave      <= bus.attr_rd_data_i[31:30];
            end
        end
    end

    // A coincident set beats the clear so no overrun is ever lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (overrun_set) begin
            overrun_q <= 1'b1;
        end else if (bus.overrun_clr_i) begin
            overrun_q <= 1'b0;
        end
    end

    assign bus.voice_valid_o  = voice_valid_q;
    assign bus.voice_idx_o    = voice_q.idx;
    assign bus.voice_phase_o  = voice_q.phase;
    assign bus.voice_volume_o = voice_q.volume;
    assign bus.voice_left_o   = voice_q.left;
    assign bus.voice_right_o  = voice_q.right;
    assign bus.voice_pw_o     = voice_q.pw;
    assign bus.voice_wave_o   = voice_q.wave;
    assign bus.sweep_done_o   = sweep_done_q;
    assign bus.overrun_o      = overrun_q;
endmodule

// File: tb/tb_audio_psg_sequencer.sv
// Scoreboard bench for audio_psg_sequencer: a phase/RAM reference model predicts
// every voice beat, and a separate monitor pops and compares as the DUT emits them.
module tb_audio_psg_sequencer;
    localparam int PHASE_W = 17;
    localparam int NV      = 16;

    typedef struct packed {
        logic [31:0]        cyc;
        logic [3:0]         idx;
        logic [PHASE_W-1:0] phase;
        logic [5:0]         vol;
        logic               left;
        logic               right;
        logic [5:0]         pw;
        logic [1:0]         wave;
        logic               done;
    } vout_t;

    logic        clk = 1'b0;
    logic        rst;
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    vout_t       sb[$];
    vout_t       last_out [NV];
    logic [31:0] ram [NV];
    int unsigned model_phase [NV];
    logic        exp_overrun;

    audio_psg_sequencer_if #(.PHASE_W(PHASE_W)) bus();

    audio_psg_sequencer #(.PHASE_W(PHASE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Attribute RAM with a registered read port.
    always @(posedge clk) begin
        if (bus.attr_rd_en_o === 1'b1) bus.attr_rd_data_i <= ram[bus.attr_rd_addr_o];
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every valid beat is compared to the oldest predicted beat.
    always @(negedge clk) begin : monitor
        vout_t act;
        vout_t exp;
        if (bus.voice_valid_o === 1'b1) begin
            act.cyc   = cyc;
            act.idx   = bus.voice_idx_o;
            act.phase = bus.voice_phase_o;
            act.vol   = bus.voice_volume_o;
            act.left  = bus.voice_left_o;
            act.right = bus.voice_right_o;
            act.pw    = bus.voice_pw_o;
            act.wave  = bus.voice_wave_o;
            act.done  = bus.sweep_done_o;
            last_out[act.idx] = act;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL voice_unexpected: got idx %0d phase %0h at cycle %0d, expected no beat",
                         act.idx, act.phase, act.cyc);
            end else begin
                exp = sb.pop_front();
                check($sformatf("voice_beat_%0d", exp.idx), 128'(act), 128'(exp));
            end
        end else if (bus.sweep_done_o === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL sweep_done_orphan: got sweep_done=1 expected 0 without a valid voice");
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of test expected completion within 500 us");
        $fatal(1, "watchdog expired");
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.sample_tick_i = 1'b0;
        bus.overrun_clr_i = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {bus.busy_o, bus.attr_rd_en_o, bus.attr_rd_addr_o, bus.voice_valid_o, bus.voice_idx_o,
               bus.voice_phase_o, bus.voice_volume_o, bus.voice_left_o, bus.voice_right_o,
               bus.voice_pw_o, bus.voice_wave_o, bus.sweep_done_o, bus.overrun_o},
              '0);
        rst = 1'b0;
        exp_overrun = 1'b0;
        for (int v = 0; v < NV; v++) model_phase[v] = 0;
    endtask

    // Cycle n below counts from the edge that samples the starting tick.
    task automatic run_sweep(input int dup_a, input int dup_b, input int clr_n, input int rst_n,
                             input int wr_n, input int wr_idx, input logic [31:0] wr_word);
        int unsigned base;
        logic [31:0] word;
        vout_t       e;
        int          last_n;
        bit          aborted;
        bit          eb, ee;
        logic [3:0]  ea;
        @(negedge clk);
        bus.sample_tick_i = 1'b1;
        bus.overrun_clr_i = 1'b0;
        base = cyc + 1;
        for (int v = 0; v < NV; v++) begin
            word = ram[v];
            if (wr_n >= 0 && v == wr_idx && wr_n <= 1 + v) word = wr_word;
            if (rst_n < 0 || 3 + v <= rst_n) begin
                model_phase[v] = (model_phase[v] + word[15:0]) % (2 ** PHASE_W);
                e.cyc   = base + 3 + v;
                e.idx   = 4'(v);
                e.phase = PHASE_W'(model_phase[v]);
                e.vol   = word[21:16];
                e.left  = word[22];
                e.right = word[23];
                e.pw    = word[29:24];
                e.wave  = word[31:30];
                e.done  = (v == NV - 1);
                sb.push_back(e);
            end
        end
        last_n = (rst_n >= 0) ? rst_n + 1 : 18;
        for (int n = 0; n <= last_n; n++) begin
            @(negedge clk);
            aborted = (rst_n >= 0 && n == rst_n + 1);
            eb = !aborted && n >= 1 && n <= 18;
            ee = !aborted && n >= 1 && n <= 16;
            ea = ee ? 4'(n - 1) : 4'd0;
            check($sformatf("sweep_ctrl_c%0d", n),
                  {bus.busy_o, bus.attr_rd_en_o, (bus.attr_rd_en_o ? bus.attr_rd_addr_o : 4'd0), bus.overrun_o},
                  {eb, ee, ea, exp_overrun});
            if (aborted) check("abort_valid", bus.voice_valid_o, 1'b0);
            bus.sample_tick_i = (n == dup_a || n == dup_b);
            bus.overrun_clr_i = (n == clr_n);
            rst = (n == rst_n);
            if (n == wr_n) ram[wr_idx] = wr_word;
            if (bus.sample_tick_i) exp_overrun = 1'b1;
            else if (bus.overrun_clr_i) exp_overrun = 1'b0;
            if (rst) exp_overrun = 1'b0;
        end
        if (rst_n >= 0) begin
            for (int v = 0; v < NV; v++) model_phase[v] = 0;
        end
    endtask

    task automatic idle(input int n_cyc, input int clr_at);
        for (int n = 0; n < n_cyc; n++) begin
            @(negedge clk);
            check("idle_ctrl", {bus.busy_o, bus.attr_rd_en_o, bus.overrun_o, bus.voice_valid_o},
                  {1'b0, 1'b0, exp_overrun, 1'b0});
            bus.sample_tick_i = 1'b0;
            bus.overrun_clr_i = (n == clr_at);
            if (bus.overrun_clr_i) exp_overrun = 1'b0;
        end
    endtask

    initial begin : stimulus
        logic [PHASE_W-1:0] t3_exp [3];
        t3_exp[0] = 17'h0FFFF;
        t3_exp[1] = 17'h1FFFE;
        t3_exp[2] = 17'h0FFFD;
        rst = 1'b1;
        bus.sample_tick_i  = 1'b0;
        bus.overrun_clr_i  = 1'b0;
        bus.attr_rd_data_i = '0;
        for (int v = 0; v < NV; v++) ram[v] = '0;
        apply_reset();

        // All-zero attributes: timing skeleton of one sweep.
        run_sweep(-1, -1, -1, -1, -1, 0, 32'h0);
        idle(2, -1);

        // One voice accumulating across four sweeps.
        ram[3] = 32'h0000_1000;
        for (int s = 0; s < 4; s++) begin
            run_sweep(-1, -1, -1, -1, -1, 0, 32'h0);
            idle(1, -1);
        end
        check("t2_phase_v3", last_out[3].phase, 17'h04000);
        check("t2_phase_v0", last_out[0].phase, 17'h00000);

        // Wrap-around at 2^17.
        ram[3] = 32'h0;
        ram[7] = 32'h0000_FFFF;
        for (int s = 0; s < 3; s++) begin
            run_sweep(-1, -1, -1, -1, -1, 0, 32'h0);
            idle(1, -1);
            check($sformatf("t3_phase_v7_s%0d", s + 1), last_out[7].phase, t3_exp[s]);
        end

        // Field decode.
        ram[5] = 32'hC5FF_1234;
        run_sweep(-1, -1, -1, -1, -1, 0, 32'h0);
        idle(1, -1);
        check("t4_fields",
              {last_out[5].wave, last_out[5].pw, last_out[5].right, last_out[5].left, last_out[5].vol},
              {2'd3, 6'd5, 1'b1, 1'b1, 6'h3F});

        // Overrun: mid-sweep and sweep_done-cycle ticks, back-to-back restart, clear, set-beats-clear.
        run_sweep(10, 18, -1, -1, -1, 0, 32'h0);
        run_sweep(-1, -1, 2, -1, -1, 0, 32'h0);
        run_sweep(5, -1, 5, -1, -1, 0, 32'h0);
        idle(3, 0);

        // Randomized attributes, gaps and mid-sweep RAM writes.
        for (int v = 0; v < NV; v++) ram[v] = $urandom();
        for (int s = 0; s < 8; s++) begin
            if ($urandom_range(0, 1) == 1)
                run_sweep(-1, -1, -1, -1, int'($urandom_range(0, 18)), int'($urandom_range(0, NV - 1)),
                          $urandom());
            else
                run_sweep(-1, -1, -1, -1, -1, 0, 32'h0);
            idle(int'($urandom_range(0, 2)), -1);
        end
        idle(1, -1);

        // Reset mid-sweep, then every phase restarts from zero.
        run_sweep(-1, -1, -1, 8, -1, 0, 32'h0);
        idle(2, -1);
        run_sweep(-1, -1, -1, -1, -1, 0, 32'h0);
        idle(2, -1);
        for (int v = 0; v < NV; v++) begin
            check($sformatf("t6_phase_v%0d", v), last_out[v].phase, PHASE_W'(ram[v][15:0]));
        end

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
